// File: rtl/demux_pkg.sv
// demux_pkg: shared select type, output count and select encodings for the 1-to-4 demux.
`default_nettype none

package demux_pkg;
  typedef logic [1:0] dsel_t;

  localparam int    NUM_OUT = 4;
  localparam dsel_t SEL_O1  = 2'b00;
  localparam dsel_t SEL_O2  = 2'b01;
  localparam dsel_t SEL_O3  = 2'b10;
  localparam dsel_t SEL_O4  = 2'b11;
endpackage

`default_nettype wire

// File: rtl/demux_slot.sv
// demux_slot: one single-entry holding slot (FULL flag, data register, availability).
// Optional per-slot delivery counter when DEMUX_COUNT_EN is defined.
`default_nettype none

module demux_slot #(
  parameter int WIDTH = 16
`ifdef DEMUX_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  output logic             o_avail
`ifdef DEMUX_COUNT_EN
  , output logic [CNT_W-1:0] o_count
`endif
);

  logic             r_full;
  logic [WIDTH-1:0] r_data;
  logic             w_drain;

  assign w_drain = r_full & i_ready;
  // A full slot being drained this cycle can take a new word on the same edge.
  assign o_avail = ~r_full | i_ready;
  assign o_valid = r_full;
  assign o_data  = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_load) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (w_drain) begin
      r_full <= 1'b0;
    end
  end

`ifdef DEMUX_COUNT_EN
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_drain) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_count = r_cnt;
`endif

endmodule

`default_nettype wire

// File: rtl/one_to_four_demux_reg.sv
// one_to_four_demux_reg: registered 1-to-4 valid/ready demux with independent per-output slots.
// Define DEMUX_COUNT_EN to add the packed per-output delivery counters on out_count.
`default_nettype none

module one_to_four_demux_reg
  import demux_pkg::*;
#(
  parameter int WIDTH = 16
`ifdef DEMUX_COUNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [NUM_OUT-1:0] out_valid,
  input  logic [NUM_OUT-1:0] out_ready,
  output logic [WIDTH-1:0]   o1,
  output logic [WIDTH-1:0]   o2,
  output logic [WIDTH-1:0]   o3,
  output logic [WIDTH-1:0]   o4
`ifdef DEMUX_COUNT_EN
  , output logic [NUM_OUT*CNT_W-1:0] out_count
`endif
);

  logic [NUM_OUT-1:0] w_dec;
  logic [NUM_OUT-1:0] w_load;
  logic [NUM_OUT-1:0] w_avail;
  logic [WIDTH-1:0]   w_data [NUM_OUT];
  logic               w_accept;
  dsel_t              w_sel;

  assign w_sel = in_sel;

  always_comb begin
    w_dec = '0;
    case (w_sel)
      SEL_O1: w_dec = 4'b0001;
      SEL_O2: w_dec = 4'b0010;
      SEL_O3: w_dec = 4'b0100;
      SEL_O4: w_dec = 4'b1000;
    endcase
  end

  // Held low while reset is asserted even though every slot reads as empty.
  assign in_ready = reset_n & w_avail[w_sel];
  assign w_accept = in_valid & in_ready;
  assign w_load   = w_dec & {NUM_OUT{w_accept}};

  generate
    for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
      demux_slot #(
        .WIDTH   (WIDTH)
`ifdef DEMUX_COUNT_EN
        , .CNT_W (CNT_W)
`endif
      ) u_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_load[k]),
        .i_data  (in_data),
        .i_ready (out_ready[k]),
        .o_valid (out_valid[k]),
        .o_data  (w_data[k]),
        .o_avail (w_avail[k])
`ifdef DEMUX_COUNT_EN
        , .o_count (out_count[k*CNT_W +: CNT_W])
`endif
      );
    end
  endgenerate

  assign o1 = w_data[0];
  assign o2 = w_data[1];
  assign o3 = w_data[2];
  assign o4 = w_data[3];

endmodule

`default_nettype wire

// File: tb/tb_one_to_four_demux_reg.sv
// tb_one_to_four_demux_reg: table vectors plus per-slot scoreboard queues for the 1-to-4 demux.
`default_nettype none

module tb_one_to_four_demux_reg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             clk;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] o1, o2, o3, o4;
`ifdef DEMUX_COUNT_EN
  logic [4*CNT_W-1:0] out_count;
`endif

  one_to_four_demux_reg #(
    .WIDTH   (WIDTH)
`ifdef DEMUX_COUNT_EN
    , .CNT_W (CNT_W)
`endif
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o1        (o1),
    .o2        (o2),
    .o3        (o3),
    .o4        (o4)
`ifdef DEMUX_COUNT_EN
    , .out_count (out_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             v;
    logic [1:0]       sel;
    logic [WIDTH-1:0] d;
    logic [3:0]       rdy;
    logic             exp_rdy;
    logic [3:0]       exp_val;
  } vec_t;

  vec_t             tbl [13];
  logic [WIDTH-1:0] sb [4][$];
  logic [CNT_W-1:0] mcnt [4];
  int               n_checks;
  int               n_fail;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] get_o(input int k);
    case (k)
      0:       return o1;
      1:       return o2;
      2:       return o3;
      default: return o4;
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      sb[k].delete();
      mcnt[k] = '0;
    end
  endtask

  // Entered just after a rising edge; samples mid-cycle, then advances one clock.
  task automatic cycle(input logic v, input logic [1:0] sel, input logic [WIDTH-1:0] d,
                       input logic [3:0] rdy, input bit tchk, input logic trdy,
                       input logic [3:0] tval);
    logic [3:0] mval;
    logic       mrdy;
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    #4;
    for (int k = 0; k < 4; k++) mval[k] = (sb[k].size() != 0);
    mrdy = !mval[sel] || rdy[sel];
    chk("in_ready", {63'd0, in_ready}, {63'd0, mrdy});
    chk("out_valid", {60'd0, out_valid}, {60'd0, mval});
    if (tchk) begin
      chk("tbl_in_ready", {63'd0, in_ready}, {63'd0, trdy});
      chk("tbl_out_valid", {60'd0, out_valid}, {60'd0, tval});
    end
    for (int k = 0; k < 4; k++) begin
      if (mval[k]) begin
        chk($sformatf("o%0d_data", k + 1), {48'd0, get_o(k)}, {48'd0, sb[k][0]});
        if (rdy[k]) begin
          void'(sb[k].pop_front());
          mcnt[k] = mcnt[k] + 1'b1;
        end
      end
    end
    if (v && mrdy) sb[sel].push_back(d);
    @(posedge clk);
    #1;
  endtask

`ifdef DEMUX_COUNT_EN
  task automatic chk_counts(input string name);
    chk(name, {32'd0, out_count}, {32'd0, mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sel    = 2'b00;
    in_data   = '0;
    out_ready = 4'b0000;
    model_clear();

    //             v     sel    data      rdy      rdy   valid
    tbl[0]  = '{1'b1, 2'd2, 16'hBEEF, 4'b0000, 1'b1, 4'b0000};
    tbl[1]  = '{1'b1, 2'd2, 16'h1111, 4'b0000, 1'b0, 4'b0100};
    tbl[2]  = '{1'b1, 2'd0, 16'hAAAA, 4'b0000, 1'b1, 4'b0100};
    tbl[3]  = '{1'b1, 2'd3, 16'h0042, 4'b0000, 1'b1, 4'b0101};
    tbl[4]  = '{1'b0, 2'd1, 16'h0000, 4'b0000, 1'b1, 4'b1101};
    tbl[5]  = '{1'b1, 2'd1, 16'h5555, 4'b0000, 1'b1, 4'b1101};
    tbl[6]  = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b1111};
    tbl[7]  = '{1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0000};
    tbl[8]  = '{1'b1, 2'd2, 16'h1234, 4'b0100, 1'b1, 4'b0000};
    tbl[9]  = '{1'b1, 2'd2, 16'h5678, 4'b0100, 1'b1, 4'b0100};
    tbl[10] = '{1'b0, 2'd2, 16'h0000, 4'b0000, 1'b0, 4'b0100};
    tbl[11] = '{1'b0, 2'd0, 16'h0000, 4'b0100, 1'b1, 4'b0100};
    tbl[12] = '{1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0000};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {60'd0, out_valid}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_data", {o4, o3, o2, o1}, 64'd0);
`ifdef DEMUX_COUNT_EN
    chk_counts("rst_count");
`endif
    reset_n = 1'b1;

    for (int i = 0; i < 13; i++)
      cycle(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].rdy, 1'b1, tbl[i].exp_rdy, tbl[i].exp_val);

    // Streaming into slot 1 with its consumer always ready.
    for (int i = 1; i <= 8; i++)
      cycle(1'b1, 2'd1, WIDTH'(i), 4'b0010, 1'b1, 1'b1, (i == 1) ? 4'b0000 : 4'b0010);
    cycle(1'b0, 2'd1, '0, 4'b0010, 1'b1, 1'b1, 4'b0010);
    cycle(1'b0, 2'd0, '0, 4'b0000, 1'b1, 1'b1, 4'b0000);

`ifdef DEMUX_COUNT_EN
    chk_counts("count_mid");
`endif

    // Asynchronous reset between edges while slots 1 and 2 hold words.
    cycle(1'b1, 2'd1, 16'hC001, 4'b0000, 1'b0, 1'b0, 4'b0000);
    cycle(1'b1, 2'd2, 16'hC002, 4'b0000, 1'b0, 1'b0, 4'b0000);
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    #2;
    chk("pre_rst_valid", {60'd0, out_valid}, 64'h6);
    reset_n = 1'b0;
    #1;
    chk("async_rst_valid", {60'd0, out_valid}, 64'd0);
    chk("async_rst_data", {o4, o3, o2, o1}, 64'd0);
    chk("async_rst_ready", {63'd0, in_ready}, 64'd0);
    model_clear();
`ifdef DEMUX_COUNT_EN
    chk_counts("async_rst_count");
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cycle(1'b1, 2'd3, 16'h7777, 4'b0000, 1'b1, 1'b1, 4'b0000);
    cycle(1'b0, 2'd3, '0, 4'b1000, 1'b1, 1'b1, 4'b1000);

`ifdef DEMUX_COUNT_EN
    model_clear();
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 257; i++)
      cycle(1'b1, 2'd2, WIDTH'(i), 4'b0100, 1'b0, 1'b0, 4'b0000);
    cycle(1'b0, 2'd2, '0, 4'b0100, 1'b0, 1'b0, 4'b0000);
    chk("count_wrap_slot2", {56'd0, out_count[23:16]}, 64'd1);
    chk("count_others", {40'd0, out_count[31:24], out_count[15:0]}, 64'd0);
    chk_counts("count_model");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
